// File: rtl/sha256_req_arbiter.sv
// sha256_req_arbiter: shares one sha256_top core between NUM_REQ message
// sources. A source owns the core for a whole message (words in, digest out),
// and ownership rotates round-robin.
// Optional feature macro: SHA_ARB_TIMEOUT_EN adds a stall watchdog, which
// resets the core and releases a stalled owner. It also adds a timeout_err port.
module sha256_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 4096,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [64*NUM_REQ-1:0]  req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   input  logic [7*NUM_REQ-1:0]   req_inv_bits,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     hash_ready,
   output logic [NUM_REQ-1:0]     hash_valid,
   output logic [255:0]           hash_out,
   output logic [63:0]            core_data_in,
   output logic                   core_data_valid,
   output logic                   core_last_block,
   output logic [6:0]             core_inv_bits,
   output logic                   core_ready_send,
   input  logic                   core_ready_rcv,
   input  logic                   core_hash_valid,
   input  logic [255:0]           core_hash_value,
   output logic                   core_srst,
   output logic [IDX_W-1:0]       grant_idx,
`ifdef SHA_ARB_TIMEOUT_EN
   output logic [NUM_REQ-1:0]     timeout_err,
`endif
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_HASH} state_t;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0] rr_reg, rr_next;
   logic [IDX_W-1:0] grant_inc;

   logic [63:0]      data_arr [NUM_REQ];
   logic [6:0]       inv_arr  [NUM_REQ];
   logic [IDX_W-1:0] cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_valid;

   logic             found;
   logic [IDX_W-1:0] winner;
   logic             word_xfer, last_xfer, hash_xfer, timeout_hit;

   // Unpack the flat requester buses and build the request vector rotated so
   // that position 0 corresponds to the round-robin pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign data_arr[gi]   = req_data[64*gi +: 64];
         assign inv_arr[gi]    = req_inv_bits[7*gi +: 7];
         assign cand_idx[gi]   = IDX_W'((32'(rr_reg) + gi) % NUM_REQ);
         assign cand_valid[gi] = req_valid[cand_idx[gi]];
      end
   endgenerate

   // Priority pick: the first requesting source at or after rr_ptr, with wrap.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            found  = 1'b1;
            winner = cand_idx[k];
         end
      end
   end

   assign grant_inc = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
   assign word_xfer = (state_reg == STREAM) && req_valid[grant_reg] && core_ready_rcv;
   assign last_xfer = word_xfer && req_last[grant_reg];
   assign hash_xfer = (state_reg == WAIT_HASH) && core_hash_valid && hash_ready[grant_reg];

`ifdef SHA_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]   wd_reg;
   logic [NUM_REQ-1:0] terr_reg;
   logic               tpulse_reg;

   assign timeout_hit = (state_reg != IDLE) && !(word_xfer || hash_xfer) &&
                        (wd_reg == CNT_W'(TIMEOUT - 1));

   // Watchdog: counts owned cycles without progress; any transfer restarts it.
   always_ff @(posedge clk) begin
      if (rst || state_reg == IDLE || word_xfer || hash_xfer || timeout_hit) begin
         wd_reg <= '0;
      end else begin
         wd_reg <= wd_reg + 1'b1;
      end
   end

   // One-cycle error flag for the stalled owner plus a one-cycle core reset.
   always_ff @(posedge clk) begin
      terr_reg   <= '0;
      tpulse_reg <= 1'b0;
      if (!rst && timeout_hit) begin
         terr_reg[grant_reg] <= 1'b1;
         tpulse_reg          <= 1'b1;
      end
   end

   assign timeout_err = terr_reg;
   assign core_srst   = rst | tpulse_reg;
`else
   assign timeout_hit = 1'b0;
   assign core_srst   = rst;
`endif

   // State, owner and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         rr_reg    <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         rr_reg    <= rr_next;
      end
   end

   // Next-state logic and the owner's pass-through muxing; outputs are held
   // quiet while reset is asserted.
   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      rr_next         = rr_reg;
      req_ready       = '0;
      hash_valid      = '0;
      hash_out        = '0;
      core_data_in    = '0;
      core_data_valid = 1'b0;
      core_last_block = 1'b0;
      core_inv_bits   = '0;
      core_ready_send = 1'b0;
      case (state_reg)
         IDLE: begin
            if (found) begin
               grant_next = winner;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (!rst) begin
               core_data_valid      = req_valid[grant_reg];
               core_data_in         = data_arr[grant_reg];
               core_last_block      = req_last[grant_reg];
               core_inv_bits        = inv_arr[grant_reg];
               req_ready[grant_reg] = core_ready_rcv;
            end
            if (last_xfer) state_next = WAIT_HASH;
         end
         WAIT_HASH: begin
            if (!rst) begin
               core_ready_send       = hash_ready[grant_reg];
               hash_valid[grant_reg] = core_hash_valid;
               hash_out              = core_hash_value;
            end
            if (hash_xfer) begin
               state_next = IDLE;
               rr_next    = grant_inc;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout_hit) begin
         state_next = IDLE;
         rr_next    = grant_inc;
      end
   end

   assign grant_idx = grant_reg;
   assign busy      = !rst && (state_reg != IDLE);

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Bench for sha256_req_arbiter: scripted random messages per requester, a
// transaction-level owner/round-robin model and a behavioural core model.
module tb_sha256_req_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready, hash_ready, hash_valid;
   logic [64*N-1:0] req_data;
   logic [7*N-1:0]  req_inv_bits;
   logic [255:0]    hash_out, core_hash_value;
   logic [63:0]     core_data_in;
   logic [6:0]      core_inv_bits;
   logic            core_data_valid, core_last_block, core_ready_send;
   logic            core_ready_rcv, core_hash_valid, core_srst, busy;
   logic [IW-1:0]   grant_idx;

   sha256_req_arbiter #(.NUM_REQ(N), .TIMEOUT(4096)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_inv_bits(req_inv_bits), .req_ready(req_ready),
      .hash_ready(hash_ready), .hash_valid(hash_valid), .hash_out(hash_out),
      .core_data_in(core_data_in), .core_data_valid(core_data_valid),
      .core_last_block(core_last_block), .core_inv_bits(core_inv_bits),
      .core_ready_send(core_ready_send), .core_ready_rcv(core_ready_rcv),
      .core_hash_valid(core_hash_valid), .core_hash_value(core_hash_value),
      .core_srst(core_srst), .grant_idx(grant_idx), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // message store: up to 2 messages of up to 16 words per requester
   logic [63:0] words [N][2][16];
   logic [6:0]  inv   [N][2];
   int          lens  [N][2];
   int          n_msgs [N];
   int          cur_msg [N];
   int          ptr [N];

   // reference model: owner (-1 = none), phase (0 words, 1 digest), rr pointer
   int m_owner, m_phase, m_rr;
   // core model
   bit           core_has_last;
   int           core_delay;
   logic [255:0] digest;
   int           obs_xfers;
   int           grants[$];
   // scenario knobs
   int gap_req, gap_after, gap_left;
   int stall_req, stall_left;
   int rst_req, rst_after;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_msgs();
      for (int i = 0; i < N; i++) begin
         n_msgs[i] = 0; cur_msg[i] = 0; ptr[i] = 0;
      end
      grants.delete();
      obs_xfers = 0;
   endtask

   task automatic load_msg(input int i, input int len, input bit zero_inv);
      int m;
      m = n_msgs[i];
      lens[i][m] = len;
      for (int w = 0; w < len; w++) words[i][m][w] = {$urandom, $urandom};
      inv[i][m] = zero_inv ? 7'd0 : 7'($urandom_range(0, 127));
      n_msgs[i]++;
   endtask

   function automatic bit all_done();
      if (m_owner >= 0) return 1'b0;
      for (int i = 0; i < N; i++) if (cur_msg[i] < n_msgs[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; req_inv_bits = '0;
      hash_ready = '0; core_ready_rcv = 1'b0; core_hash_valid = 1'b0; core_hash_value = '0;
      @(negedge clk);
      chk("rst_srst", 256'(core_srst), 256'(1));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_req_ready", 256'(req_ready), 256'(0));
      chk("rst_hash_valid", 256'(hash_valid), 256'(0));
      chk("rst_core_valid", 256'(core_data_valid), 256'(0));
      chk("rst_core_last", 256'(core_last_block), 256'(0));
      chk("rst_ready_send", 256'(core_ready_send), 256'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_srst", 256'(core_srst), 256'(0));
      chk("rst_grant_idx", 256'(grant_idx), 256'(0));
      @(posedge clk); #1;
      m_owner = -1; m_phase = 0; m_rr = 0; core_has_last = 1'b0; core_delay = 0;
   endtask

   task automatic run(input int budget);
      int cyc, g, m, p;
      logic [N-1:0] v, exp_v;
      bit do_rst, xfer, hs;
      cyc = 0;
      forever begin
         if (all_done()) break;
         if (cyc >= budget) begin
            chk("cycle_budget", 256'(1), 256'(0));
            break;
         end
         cyc++;
         do_rst = 1'b0; xfer = 1'b0; hs = 1'b0; g = m_owner;
         // requester drive
         v = '0;
         for (int i = 0; i < N; i++) begin
            req_data[64*i +: 64] = '0; req_last[i] = 1'b0; req_inv_bits[7*i +: 7] = '0;
            if (cur_msg[i] < n_msgs[i] && ptr[i] < lens[i][cur_msg[i]]) begin
               m = cur_msg[i]; p = ptr[i];
               v[i] = 1'b1;
               req_data[64*i +: 64]    = words[i][m][p];
               req_last[i]             = (p == lens[i][m] - 1);
               req_inv_bits[7*i +: 7]  = inv[i][m];
            end
         end
         if (g >= 0 && m_phase == 0) begin
            if (g == gap_req && ptr[g] == gap_after && gap_left > 0) begin
               v[g] = 1'b0; gap_left--;
            end else if ($urandom_range(0, 7) == 0) begin
               v[g] = 1'b0;
            end
            if (g == rst_req && ptr[g] == rst_after) begin
               do_rst = 1'b1; rst_req = -1;
            end
         end
         req_valid = v;
         rst = do_rst;
         core_ready_rcv = ($urandom_range(0, 4) != 0);
         for (int i = 0; i < N; i++) hash_ready[i] = ($urandom_range(0, 3) != 0);
         if (g >= 0 && m_phase == 1 && g == stall_req && stall_left > 0) begin
            hash_ready[g] = 1'b0; stall_left--;
         end
         if (g >= 0 && m_phase == 1 && core_has_last) begin
            if (core_delay > 0) begin
               core_delay--; core_hash_valid = 1'b0; core_hash_value = '0;
            end else begin
               core_hash_valid = 1'b1; core_hash_value = digest;
            end
         end else begin
            core_hash_valid = ($urandom_range(0, 3) == 0);
            core_hash_value = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end

         @(negedge clk);
         if (core_data_valid && core_ready_rcv) obs_xfers++;
         if (do_rst) begin
            chk("midrst_srst", 256'(core_srst), 256'(1));
            chk("midrst_busy", 256'(busy), 256'(0));
            chk("midrst_req_ready", 256'(req_ready), 256'(0));
            chk("midrst_core_valid", 256'(core_data_valid), 256'(0));
            chk("midrst_hash_valid", 256'(hash_valid), 256'(0));
         end else if (g < 0) begin
            chk("idle_busy", 256'(busy), 256'(0));
            chk("idle_req_ready", 256'(req_ready), 256'(0));
            chk("idle_hash_valid", 256'(hash_valid), 256'(0));
            chk("idle_core_valid", 256'(core_data_valid), 256'(0));
            chk("idle_ready_send", 256'(core_ready_send), 256'(0));
         end else if (m_phase == 0) begin
            exp_v = '0; exp_v[g] = core_ready_rcv;
            chk("str_busy", 256'(busy), 256'(1));
            chk("str_req_ready", 256'(req_ready), 256'(exp_v));
            chk("str_core_valid", 256'(core_data_valid), 256'(v[g]));
            chk("str_hash_valid", 256'(hash_valid), 256'(0));
            chk("str_ready_send", 256'(core_ready_send), 256'(0));
            if (v[g]) begin
               m = cur_msg[g]; p = ptr[g];
               chk("str_data", 256'(core_data_in), 256'(words[g][m][p]));
               chk("str_last", 256'(core_last_block), 256'(p == lens[g][m] - 1));
               if (p == lens[g][m] - 1) chk("str_inv", 256'(core_inv_bits), 256'(inv[g][m]));
            end
            xfer = v[g] && core_ready_rcv;
         end else begin
            exp_v = '0; exp_v[g] = core_hash_valid;
            chk("wh_req_ready", 256'(req_ready), 256'(0));
            chk("wh_core_valid", 256'(core_data_valid), 256'(0));
            chk("wh_ready_send", 256'(core_ready_send), 256'(hash_ready[g]));
            chk("wh_hash_valid", 256'(hash_valid), 256'(exp_v));
            if (core_hash_valid) chk("wh_hash_out", hash_out, digest);
            hs = core_hash_valid && hash_ready[g];
         end

         @(posedge clk); #1;
         if (do_rst) begin
            chk("midrst_grant_idx", 256'(grant_idx), 256'(0));
            ptr[g] = 0; m_owner = -1; m_phase = 0; m_rr = 0; core_has_last = 1'b0;
         end else if (g < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
               if (v[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
            end
            if (m_owner >= 0) begin
               m_phase = 0;
               grants.push_back(m_owner);
               chk("grant_idx", 256'(grant_idx), 256'(m_owner));
            end
         end else if (m_phase == 0) begin
            if (xfer) begin
               ptr[g]++;
               if (ptr[g] == lens[g][cur_msg[g]]) begin
                  m_phase = 1; core_has_last = 1'b1; core_delay = $urandom_range(0, 3);
                  digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               end
            end
         end else if (hs) begin
            $display("digest req=%0d words=%0d hash=%h", g, lens[g][cur_msg[g]], digest);
            m_owner = -1; m_rr = (g + 1) % N; cur_msg[g]++; ptr[g] = 0; core_has_last = 1'b0;
         end
      end
   endtask

   initial begin
      gap_req = -1; gap_after = 0; gap_left = 0;
      stall_req = -1; stall_left = 0;
      rst_req = -1; rst_after = 0;
      clear_msgs();
      do_reset();

      // single 8-word message from req0
      clear_msgs();
      load_msg(0, 8, 1'b1);
      run(500);
      chk("single_xfers", 256'(obs_xfers), 256'(8));
      chk("single_ngrants", 256'(grants.size()), 256'(1));

      // contention 0,1,3 with a second req0 message; rr back at 0
      do_reset();
      clear_msgs();
      load_msg(0, 3, 1'b0); load_msg(1, 4, 1'b0); load_msg(3, 2, 1'b0); load_msg(0, 5, 1'b0);
      run(800);
      chk("cont_ngrants", 256'(grants.size()), 256'(4));
      if (grants.size() == 4) begin
         chk("cont_g0", 256'(grants[0]), 256'(0));
         chk("cont_g1", 256'(grants[1]), 256'(1));
         chk("cont_g2", 256'(grants[2]), 256'(3));
         chk("cont_g3", 256'(grants[3]), 256'(0));
      end

      // digest backpressure on req2 while req3 waits (rr now 1)
      clear_msgs();
      stall_req = 2; stall_left = 20;
      load_msg(2, 4, 1'b0); load_msg(3, 3, 1'b0);
      run(800);
      chk("bp_stall_used", 256'(stall_left), 256'(0));
      chk("bp_ngrants", 256'(grants.size()), 256'(2));
      if (grants.size() == 2) begin
         chk("bp_g0", 256'(grants[0]), 256'(2));
         chk("bp_g1", 256'(grants[1]), 256'(3));
      end
      stall_req = -1;

      // req1 pauses 5 cycles after word 3 while req2 is pending (rr now 0)
      clear_msgs();
      gap_req = 1; gap_after = 3; gap_left = 5;
      load_msg(1, 8, 1'b0); load_msg(2, 3, 1'b0);
      run(800);
      chk("gap_used", 256'(gap_left), 256'(0));
      chk("gap_ngrants", 256'(grants.size()), 256'(2));
      if (grants.size() == 2) begin
         chk("gap_g0", 256'(grants[0]), 256'(1));
         chk("gap_g1", 256'(grants[1]), 256'(2));
      end
      gap_req = -1;

      // reset after word 4 of req2; req2 resends the whole message
      clear_msgs();
      rst_req = 2; rst_after = 4;
      load_msg(2, 8, 1'b0);
      run(800);
      chk("rst_fired", 256'(rst_req), 256'(-1));
      chk("rst_ngrants", 256'(grants.size()), 256'(2));
      if (grants.size() == 2) begin
         chk("rst_g0", 256'(grants[0]), 256'(2));
         chk("rst_g1", 256'(grants[1]), 256'(2));
      end

      // random mix: two messages per requester, lengths 1..12
      clear_msgs();
      for (int i = 0; i < N; i++) begin
         load_msg(i, $urandom_range(1, 12), 1'b0);
         load_msg(i, $urandom_range(1, 12), 1'b0);
      end
      run(3000);
      chk("mix_ngrants", 256'(grants.size()), 256'(8));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
